// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a DIGITS-wide common-anode seven-segment bank.
//   A packed BCD word is captured on load into a shadow register. One digit is
//   lit per scan slot of SCAN_DIV cycles. The last cycle of every slot is dark,
//   which stops the old segment pattern ghosting onto the next digit.
//   Extra features:
//     - leading-zero blanking
//     - a dash for codes 10..15
//     - optional per-digit blink
//
//   Optional feature macro: SEG7_SCAN_BLINK_EN
//     When defined, this adds the blink port and a frame counter. The blink
//     phase toggles every BLINK_DIV completed frames.
//
// Ports
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   bcd_in  packed BCD, digit i = bcd_in[4i+3:4i]
//   load    copy bcd_in into the shadow register
//   en      display enable (0 = dark)
//   lzb     leading-zero blanking enable
//   blink   per-digit blink mask (SEG7_SCAN_BLINK_EN only)
//   seg     segments a..g, active-low, seg[0]=a (registered)
//   an      anode selects, active-low, at most one low (registered)
module seg7_scan_driver #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic                  en,
  input  logic                  lzb,
`ifdef SEG7_SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink,
`endif
  output logic [0:6]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned PrescW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW   = $clog2(DIGITS);

  // Elaboration-time parameter checks.
  if (DIGITS < 2) begin : g_bad_digits
    $error("DIGITS must be >= 2");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be >= 2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be >= 1");
  end

  // Active-low a..g; the leftmost literal bit lands in seg[0] (segment a).
  function automatic logic [0:6] decode(input logic [3:0] d);
    logic [0:6] s;
    unique case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [0:6]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                guard;
  logic [DIGITS-1:0]   lead_zero;
  logic                all_zero;
  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [DIGITS-1:0]   an_sel;

  // Last prescaler count of a slot: outputs dark, idx steps on this edge.
  assign guard = (presc_q == PrescW'(SCAN_DIV - 1));

  // Load and scan paths are fully independent.
  always_comb begin
    shadow_d = load ? bcd_in : shadow_q;
    presc_d  = guard ? '0 : presc_q + PrescW'(1);
    idx_d    = idx_q;
    if (guard) begin
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

`ifdef SEG7_SCAN_BLINK_EN
  localparam int unsigned FrameW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic              phase_q, phase_d;
  logic              frame_done;

  // A frame completes on the guard edge that wraps idx from DIGITS-1 to 0.
  assign frame_done = guard && (idx_q == IdxW'(DIGITS - 1));

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frame_done) begin
      if (frame_cnt_q == FrameW'(BLINK_DIV - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FrameW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end
`endif

  // lead_zero[i] = every digit from DIGITS-1 down to i is exactly 0.
  // Codes 10..15 are nonzero, so they stop the blanking run.
  always_comb begin
    lead_zero = '0;
    all_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (shadow_q[4*i +: 4] == 4'h0);
      lead_zero[i] = all_zero;
    end
  end

  // A blanked digit keeps its anode low; only the segments go dark.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b0;
    an_sel    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_digit = shadow_q[4*i +: 4];
        cur_blank = (i != 0) && lzb && lead_zero[i];
`ifdef SEG7_SCAN_BLINK_EN
        cur_blank = cur_blank | (phase_q & blink[i]);
`endif
        an_sel[i] = 1'b0;
      end
    end

    if (!en || guard) begin
      seg_d = '1;
      an_d  = '1;
    end else begin
      an_d  = an_sel;
      seg_d = cur_blank ? 7'b1111111 : decode(cur_digit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= '1;
      an_q     <= '1;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
// Each step queues the expected {an, seg} for the coming edge, then checks it.
// The expected value comes either from a constant or from a small behavioural
// model, and is compared after the edge.
module tb_seg7_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] bcd_in = 16'h0;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic        lzb = 1'b0;
  logic [0:6]  seg;
  logic [3:0]  an;
`ifdef SEG7_SCAN_BLINK_EN
  logic [3:0]  blink = 4'b0000;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [10:0] sb_q[$];
  string       tag_q[$];

  // Model state (pre-edge view).
  int          m_presc;
  int          m_idx;
  logic [15:0] m_shadow;
`ifdef SEG7_SCAN_BLINK_EN
  int          m_frames;
  bit          m_phase;
`endif

  seg7_scan_driver #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bcd_in(bcd_in),
    .load  (load),
    .en    (en),
    .lzb   (lzb),
`ifdef SEG7_SCAN_BLINK_EN
    .blink (blink),
`endif
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  function automatic logic [10:0] model_out();
    logic [3:0] d;
    logic       blank;
    logic [3:0] a;
    if (!en || m_presc == SCAN_DIV - 1) return 11'h7ff;
    d     = m_shadow[4*m_idx +: 4];
    blank = 1'b0;
    if (lzb && m_idx > 0) begin
      blank = 1'b1;
      for (int k = m_idx; k < DIGITS; k++) begin
        if (m_shadow[4*k +: 4] != 4'h0) blank = 1'b0;
      end
    end
`ifdef SEG7_SCAN_BLINK_EN
    if (m_phase && blink[m_idx]) blank = 1'b1;
`endif
    a = ~(4'b0001 << m_idx);
    return {a, blank ? 7'b1111111 : dec(d)};
  endfunction

  task automatic model_reset();
    m_presc  = 0;
    m_idx    = 0;
    m_shadow = 16'h0;
`ifdef SEG7_SCAN_BLINK_EN
    m_frames = 0;
    m_phase  = 1'b0;
`endif
  endtask

  task automatic model_advance();
    if (m_presc == SCAN_DIV - 1) begin
      m_presc = 0;
      if (m_idx == DIGITS - 1) begin
        m_idx = 0;
`ifdef SEG7_SCAN_BLINK_EN
        m_frames++;
        if (m_frames == BLINK_DIV) begin
          m_frames = 0;
          m_phase  = ~m_phase;
        end
`endif
      end else begin
        m_idx++;
      end
    end else begin
      m_presc++;
    end
    if (load) m_shadow = bcd_in;
  endtask

  // One clock: queue the expectation, advance the model, clock, then compare.
  task automatic step(input string tag, input bit use_const, input logic [10:0] c);
    logic [10:0] exp_v;
    string       t;
    sb_q.push_back(use_const ? c : model_out());
    tag_q.push_back(tag);
    model_advance();
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    t     = tag_q.pop_front();
    vectors++;
    assert ({an, seg} === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed an=%b seg=%b, expected an=%b seg=%b",
             t, an, seg, exp_v[10:7], exp_v[6:0]);
    end
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 11'h0);
  endtask

  task automatic check_dark(input string tag);
    vectors++;
    assert ({an, seg} === 11'h7ff) else begin
      miscompares++;
      $error("FAIL %s: observed an=%b seg=%b, expected an=1111 seg=1111111", tag, an, seg);
    end
  endtask

  logic [3:0] an_tab[4];
  logic [6:0] seg_tab[4];

  initial begin
    an_tab[0] = 4'b1110; seg_tab[0] = 7'b1001100;
    an_tab[1] = 4'b1101; seg_tab[1] = 7'b0000110;
    an_tab[2] = 4'b1011; seg_tab[2] = 7'b0010010;
    an_tab[3] = 4'b0111; seg_tab[3] = 7'b1001111;

    // Power-on reset, released between edges.
    #1 rst_n = 1'b0;
    model_reset();
    #10 check_dark("reset_state");
    #1 rst_n = 1'b1;

    // 1234: the first edge still shows the reset shadow digit 0.
    en = 1'b1; bcd_in = 16'h1234; load = 1'b1;
    step("first_edge", 1'b1, {4'b1110, 7'b0000001});
    load = 1'b0;
    step("d0_lit_a", 1'b1, {4'b1110, 7'b1001100});
    step("d0_lit_b", 1'b1, {4'b1110, 7'b1001100});
    step("d0_guard", 1'b1, 11'h7ff);
    for (int f = 0; f < 2; f++) begin
      for (int d = (f == 0) ? 1 : 0; d < DIGITS; d++) begin
        for (int p = 0; p < SCAN_DIV - 1; p++) step("frame1234", 1'b1, {an_tab[d], seg_tab[d]});
        step("guard1234", 1'b1, 11'h7ff);
      end
    end

    // Leading-zero blanking, then the same value unblanked.
    bcd_in = 16'h0070; lzb = 1'b1; load = 1'b1;
    step("load0070", 1'b0, 11'h0);
    load = 1'b0;
    run("lzb_0070", 16);
    lzb = 1'b0;
    run("nolzb_0070", 16);

    // A non-BCD code is nonzero, so it is not blanked and shows a dash.
    bcd_in = 16'h00A5; lzb = 1'b1; load = 1'b1;
    step("load00a5", 1'b0, 11'h0);
    load = 1'b0;
    run("lzb_00a5", 16);
    lzb = 1'b0;

    // Enable dropped mid-slot; the scan keeps its place.
    bcd_in = 16'h1234; load = 1'b1;
    step("load1234b", 1'b0, 11'h0);
    load = 1'b0;
    run("pre_en", 5);
    en = 1'b0;
    step("en_off", 1'b1, 11'h7ff);
    run("en_off_hold", 2);
    en = 1'b1;
    run("en_resume", 12);

    // Asynchronous reset mid-slot, with no clock edge while it is low.
    #2 rst_n = 1'b0;
    #1 check_dark("async_reset");
    #1 rst_n = 1'b1;
    model_reset();
    load = 1'b1;
    step("post_reset_first", 1'b1, {4'b1110, 7'b0000001});
    load = 1'b0;
    run("post_reset_scan", 19);

`ifdef SEG7_SCAN_BLINK_EN
    blink = 4'b0001;
    run("blink", 6 * DIGITS * SCAN_DIV);
    blink = 4'b0000;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
